// File: rtl/cpu_mem_arbiter_pkg.sv
// Shared types and constants for the CPU instruction/data memory arbiter.
package cpu_mem_arbiter_pkg;

   // Memory access size, shared with the memory block.
   typedef enum logic [1:0] {
      DT_BYTE = 2'd0,
      DT_HALF = 2'd1,
      DT_WORD = 2'd2
   } mem_dt_e;

   // Error codes returned by the memory.
   typedef enum logic [2:0] {
      ENONE  = 3'd0,
      EALIGN = 3'd1,
      EBUS   = 3'd2,
      EPERM  = 3'd3
   } errno_e;

   typedef enum logic [1:0] {
      ARB_IDLE   = 2'd0,
      ARB_ACCESS = 2'd1,
      ARB_RESP   = 2'd2
   } arb_state_e;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_I    = 2'd1,
      OWN_D    = 2'd2
   } arb_owner_e;

   localparam int unsigned MEM_LAT_MAX = 7;
   localparam int unsigned CNT_W       = $clog2(MEM_LAT_MAX + 1);
   // Wide enough for a MAX_STREAK of up to 15.
   localparam int unsigned STREAK_W    = 4;

endpackage

// File: rtl/cpu_mem_arbiter_prio_sel.sv
// Grant selection: data wins unless it has hogged the memory for MAX_STREAK grants
// while a fetch was waiting.
module arb_prio_sel
   import cpu_mem_arbiter_pkg::*;
#(
   parameter int unsigned MAX_STREAK = 4
) (
   input  logic                i_req,
   input  logic                d_req,
   input  logic [STREAK_W-1:0] streak,
   output logic                grant_i,
   output logic                grant_d
);

   // Fetch only preempts data once the streak limit is reached.
   always_comb begin
      grant_i = i_req && (!d_req || (streak == STREAK_W'(MAX_STREAK)));
      grant_d = d_req && !grant_i;
   end

endmodule

// File: rtl/cpu_mem_arbiter.sv
// Shares one single-port memory between the CPU fetch port and data port.
// Each access walks IDLE -> ACCESS (MEM_LAT+1 cycles) -> RESP (ack pulse).
module cpu_mem_arbiter
   import cpu_mem_arbiter_pkg::*;
#(
   parameter int unsigned MEM_LAT    = 1,
   parameter int unsigned MAX_STREAK = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_req,
   input  logic [31:0] i_addr,
   output logic        i_ack,
   output logic [31:0] i_rd,
   output errno_e      i_err,
   input  logic        d_req,
   input  logic [31:0] d_addr,
   input  logic        d_we,
   input  logic [31:0] d_wd,
   input  mem_dt_e     d_dt,
   output logic        d_ack,
   output logic [31:0] d_rd,
   output errno_e      d_err,
   output logic        m_en,
   output logic [31:0] m_addr,
   output logic        m_we,
   output logic [31:0] m_wd,
   output mem_dt_e     m_dt,
   input  logic [31:0] m_rd,
   input  errno_e      m_err,
   output logic        busy
);

   arb_state_e          state;
   arb_owner_e          owner;
   logic [CNT_W-1:0]    cnt;
   logic [STREAK_W-1:0] streak;
   logic                grant_i;
   logic                grant_d;

   arb_prio_sel #(
      .MAX_STREAK(MAX_STREAK)
   ) u_prio_sel (
      .i_req  (i_req),
      .d_req  (d_req),
      .streak (streak),
      .grant_i(grant_i),
      .grant_d(grant_d)
   );

   // Arbiter FSM with all outputs registered.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= ARB_IDLE;
         owner  <= OWN_NONE;
         cnt    <= '0;
         streak <= '0;
         i_ack  <= 1'b0;
         i_rd   <= '0;
         i_err  <= ENONE;
         d_ack  <= 1'b0;
         d_rd   <= '0;
         d_err  <= ENONE;
         m_en   <= 1'b0;
         m_addr <= '0;
         m_we   <= 1'b0;
         m_wd   <= '0;
         m_dt   <= DT_WORD;
         busy   <= 1'b0;
      end else begin
         // Strobes default low; each is raised for exactly one cycle below.
         m_en  <= 1'b0;
         i_ack <= 1'b0;
         d_ack <= 1'b0;
         case (state)
            ARB_IDLE: begin
               if (grant_i) begin
                  owner  <= OWN_I;
                  m_addr <= i_addr;
                  m_we   <= 1'b0;
                  m_wd   <= '0;
                  m_dt   <= DT_WORD;
                  streak <= '0;
               end else if (grant_d) begin
                  owner  <= OWN_D;
                  m_addr <= d_addr;
                  m_we   <= d_we;
                  m_wd   <= d_wd;
                  m_dt   <= d_dt;
                  if (!i_req) begin
                     streak <= '0;
                  end else if (streak != STREAK_W'(MAX_STREAK)) begin
                     streak <= streak + STREAK_W'(1);
                  end
               end
               if (grant_i || grant_d) begin
                  cnt   <= CNT_W'(MEM_LAT);
                  m_en  <= 1'b1;
                  busy  <= 1'b1;
                  state <= ARB_ACCESS;
               end
            end
            ARB_ACCESS: begin
               if (cnt == '0) begin
                  if (owner == OWN_I) begin
                     i_rd  <= m_rd;
                     i_err <= m_err;
                     i_ack <= 1'b1;
                  end else begin
                     d_rd  <= m_rd;
                     d_err <= m_err;
                     d_ack <= 1'b1;
                  end
                  state <= ARB_RESP;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            ARB_RESP: begin
               owner <= OWN_NONE;
               busy  <= 1'b0;
               state <= ARB_IDLE;
            end
            default: begin
               owner <= OWN_NONE;
               busy  <= 1'b0;
               state <= ARB_IDLE;
            end
         endcase
      end
   end

endmodule
